// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: instruction-fetch stage controller.
// Generates the fetch PC, drives the inst SRAM-like req/addr_ok/data_ok handshake, and buffers
// in-order responses in a small pc/inst queue. After a redirect, responses to requests that were
// issued before it are counted and dropped. The head entry goes to ID through valid/allow_in.
// Ports:
//   aclk, reset                      clock, synchronous active-high reset
//   inst_req/inst_addr (out)         fetch request and its word address, held until addr_ok
//   inst_addr_ok/inst_data_ok (in)   request accepted / one in-order response returned
//   inst_rdata (in)                  response instruction word
//   redirect_valid/redirect_pc (in)  flush from MEM/WB (highest priority)
//   br_taken/br_target (in)          taken branch resolved in ID
//   id_allow_in (in)                 ID accepts the head entry
//   if_valid_out/if_pc/if_inst/if_adef (out)  head entry handed to ID

module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        aclk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allow_in,
    output logic        if_valid_out,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int EW = CW + 1;
    localparam logic [CW-1:0]        DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [BUF_DEPTH-1:0] ONE_C   = BUF_DEPTH'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ADEF = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           req_q, req_d;
    logic [31:0]    req_addr_q, req_addr_d;
    logic           req_stale_q, req_stale_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  discard_q, discard_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [BUF_DEPTH-1:0] filled_q, filled_d;
    logic [31:0]    pc_buf_q   [BUF_DEPTH];
    logic [31:0]    inst_buf_q [BUF_DEPTH];

    logic           accept_s, redir_s, drop_s, fill_s, pop_s, push_s, stale_acc_s;
    logic           req_hold_s, head_filled_s, adef_ready_s, adef_s;
    logic [31:0]    target_s;
    logic [EW-1:0]  discard_w_s, inflight_w_s, count_w_s;
    logic [BUF_DEPTH-1:0] fill_mask_s, pop_mask_s;

    // Handshake events and redirect selection for this cycle.
    always_comb begin
        accept_s      = req_q & inst_addr_ok;
        redir_s       = redirect_valid | br_taken;
        target_s      = redirect_valid ? redirect_pc : br_target;
        drop_s        = inst_data_ok & (discard_q != {CW{1'b0}});
        fill_s        = inst_data_ok & (discard_q == {CW{1'b0}}) & (inflight_q != {CW{1'b0}});
        head_filled_s = filled_q[head_q];
        pop_s         = head_filled_s & id_allow_in;
        // A request held across a redirect carries the old address: it is counted as stale.
        push_s        = accept_s & ~req_stale_q & ~redir_s;
        stale_acc_s   = accept_s & (req_stale_q | redir_s);
        req_hold_s    = req_q & ~inst_addr_ok;
        fill_mask_s   = fill_s ? (ONE_C << fill_q) : {BUF_DEPTH{1'b0}};
        pop_mask_s    = pop_s ? (ONE_C << head_q) : {BUF_DEPTH{1'b0}};
    end

    // Counter, pointer and fetch-PC next state; counters computed one bit wider for range checks.
    always_comb begin
        discard_w_s  = EW'(discard_q);
        inflight_w_s = EW'(inflight_q);
        count_w_s    = EW'(count_q);
        fetch_pc_d   = fetch_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_d       = fill_q;
        filled_d     = filled_q;
        if (redir_s) begin
            // A same-cycle response is settled against the old counts, then everything
            // still outstanding (including this cycle's accept) becomes discard.
            discard_w_s  = EW'(discard_q) - EW'(drop_s) + EW'(inflight_q) - EW'(fill_s)
                           + EW'(accept_s);
            inflight_w_s = {EW{1'b0}};
            count_w_s    = {EW{1'b0}};
            fetch_pc_d   = target_s;
            head_d       = {PW{1'b0}};
            tail_d       = {PW{1'b0}};
            fill_d       = {PW{1'b0}};
            filled_d     = {BUF_DEPTH{1'b0}};
        end else begin
            discard_w_s  = EW'(discard_q) - EW'(drop_s) + EW'(stale_acc_s);
            inflight_w_s = EW'(inflight_q) + EW'(push_s) - EW'(fill_s);
            count_w_s    = EW'(count_q) + EW'(push_s) - EW'(pop_s);
            fetch_pc_d   = push_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
            head_d       = head_q + PW'(pop_s);
            tail_d       = tail_q + PW'(push_s);
            fill_d       = fill_q + PW'(fill_s);
            filled_d     = (filled_q | fill_mask_s) & ~pop_mask_s;
        end
        discard_d  = discard_w_s[CW-1:0];
        inflight_d = inflight_w_s[CW-1:0];
        count_d    = count_w_s[CW-1:0];
    end

    // Request generation: hold an unaccepted request, otherwise issue from the next fetch PC.
    always_comb begin
        if (req_hold_s) begin
            req_d       = 1'b1;
            req_addr_d  = req_addr_q;
            req_stale_d = req_stale_q | redir_s;
        end else begin
            req_d       = (fetch_pc_d[1:0] == 2'b00) & (count_d < DEPTH_C);
            req_addr_d  = fetch_pc_d;
            req_stale_d = 1'b0;
        end
    end

    // FSM next state: RUN issues, HOLD waits for addr_ok, ADEF presents the misaligned PC.
    always_comb begin
        adef_ready_s = (fetch_pc_d[1:0] != 2'b00) & (count_d == {CW{1'b0}}) & ~req_hold_s;
        state_d      = state_q;
        case (state_q)
            ST_RUN, ST_HOLD: begin
                if (req_hold_s) begin
                    state_d = ST_HOLD;
                end else if (adef_ready_s) begin
                    state_d = ST_ADEF;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ADEF: begin
                if (redir_s && (target_s[1:0] == 2'b00)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ADEF;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, counter and queue registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            fetch_pc_q  <= RESET_PC;
            req_q       <= 1'b0;
            req_addr_q  <= RESET_PC;
            req_stale_q <= 1'b0;
            inflight_q  <= {CW{1'b0}};
            discard_q   <= {CW{1'b0}};
            count_q     <= {CW{1'b0}};
            head_q      <= {PW{1'b0}};
            tail_q      <= {PW{1'b0}};
            fill_q      <= {PW{1'b0}};
            filled_q    <= {BUF_DEPTH{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_buf_q[i]   <= 32'h0;
                inst_buf_q[i] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_q       <= req_d;
            req_addr_q  <= req_addr_d;
            req_stale_q <= req_stale_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            filled_q    <= filled_d;
            if (push_s) begin
                pc_buf_q[tail_q] <= req_addr_q;
            end
            if (fill_s) begin
                inst_buf_q[fill_q] <= inst_rdata;
            end
        end
    end

    // Outputs come straight from registers; ADEF overrides the (empty) queue head.
    always_comb begin
        adef_s       = (state_q == ST_ADEF);
        inst_req     = req_q;
        inst_addr    = req_addr_q;
        if_valid_out = adef_s | head_filled_s;
        if_adef      = adef_s;
        if_pc        = adef_s ? fetch_pc_q : pc_buf_q[head_q];
        if_inst      = adef_s ? 32'h0 : inst_buf_q[head_q];
    end

    fetch_stage_ctrl_chk #(.CW(CW), .BUF_DEPTH(BUF_DEPTH)) u_chk (
        .clk          (aclk),
        .reset        (reset),
        .data_ok      (inst_data_ok),
        .inflight     (inflight_q),
        .discard      (discard_q),
        .inflight_nxt (inflight_w_s),
        .discard_nxt  (discard_w_s),
        .count_nxt    (count_w_s)
    );
endmodule

// fetch_stage_ctrl_chk: protocol and counter-range checks for fetch_stage_ctrl.
// Ports: clk/reset, data_ok, current counters, and the one-bit-wider next counter values.
module fetch_stage_ctrl_chk #(
    parameter int CW        = 2,
    parameter int BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          data_ok,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] discard,
    input logic [CW:0]   inflight_nxt,
    input logic [CW:0]   discard_nxt,
    input logic [CW:0]   count_nxt
);
    // Flag unexpected responses and counter over/underflow on every active edge.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(data_ok && (inflight == {CW{1'b0}}) && (discard == {CW{1'b0}})))
                else $error("fetch_stage_ctrl: data_ok with nothing outstanding");
            assert (inflight_nxt[CW] == 1'b0)
                else $error("fetch_stage_ctrl: inflight out of range");
            assert (discard_nxt[CW] == 1'b0)
                else $error("fetch_stage_ctrl: discard out of range");
            assert (count_nxt <= (CW+1)'(BUF_DEPTH))
                else $error("fetch_stage_ctrl: queue occupancy out of range");
        end
    end
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;
    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        aclk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_allow_in;
    logic        if_valid_out;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adef;

    fetch_stage_ctrl #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
        .aclk           (aclk),
        .reset          (reset),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .id_allow_in    (id_allow_in),
        .if_valid_out   (if_valid_out),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_adef        (if_adef)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pend[$];
    logic [31:0] dpc[$];
    logic [31:0] dinst[$];
    logic        aok_en, resp_en, req_seen;
    int          acc_total, max_out;
    vec_t        tbl[9];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic vec_t mk(input logic aok, input logic dok, input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = inst_of(e_pc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle with the memory model: responses in order, one cycle after accept at the earliest.
    task automatic cyc();
        logic do_acc;
        inst_addr_ok = aok_en;
        inst_data_ok = resp_en && (pend.size() > 0);
        if (inst_data_ok) inst_rdata = inst_of(pend[0]);
        else inst_rdata = 32'h0;
        do_acc = inst_req && inst_addr_ok;
        if (inst_data_ok) void'(pend.pop_front());
        if (do_acc) begin
            pend.push_back(inst_addr);
            acc_total++;
        end
        if (inst_req) req_seen = 1'b1;
        if (if_valid_out && id_allow_in && !if_adef) begin
            dpc.push_back(if_pc);
            dinst.push_back(if_inst);
        end
        if (acc_total - dpc.size() > max_out) max_out = acc_total - dpc.size();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; br_taken = 1'b0; br_target = 32'h0;
        id_allow_in = 1'b1;
        aok_en = 1'b1; resp_en = 1'b1; req_seen = 1'b0;
        acc_total = 0; max_out = 0;
        pend.delete(); dpc.delete(); dinst.delete();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        reset = 1'b0;
    endtask

    task automatic check_deliv(input string name, input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= dpc.size()) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: only %0d deliveries, expected at least %0d", name, dpc.size(), n);
                break;
            end
            chk($sformatf("%s_pc%0d", name, i), dpc[i], start + 32'd4 * 32'(i));
            chk($sformatf("%s_inst%0d", name, i), dinst[i], inst_of(start + 32'd4 * 32'(i)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Test 1: cycle-exact table after reset, addr_ok high, responses one cycle after accept.
        tbl[0] = mk(1'b1, 1'b0, 32'h0,                  1'b0, 32'h0,        1'b0, 32'h0);
        tbl[1] = mk(1'b1, 1'b0, 32'h0,                  1'b1, RPC,          1'b0, 32'h0);
        tbl[2] = mk(1'b1, 1'b1, inst_of(RPC),           1'b1, RPC + 32'h4,  1'b0, 32'h0);
        tbl[3] = mk(1'b1, 1'b1, inst_of(RPC + 32'h4),   1'b0, 32'h0,        1'b1, RPC);
        tbl[4] = mk(1'b1, 1'b0, 32'h0,                  1'b1, RPC + 32'h8,  1'b1, RPC + 32'h4);
        tbl[5] = mk(1'b1, 1'b1, inst_of(RPC + 32'h8),   1'b1, RPC + 32'hc,  1'b0, 32'h0);
        tbl[6] = mk(1'b1, 1'b1, inst_of(RPC + 32'hc),   1'b0, 32'h0,        1'b1, RPC + 32'h8);
        tbl[7] = mk(1'b0, 1'b0, 32'h0,                  1'b1, RPC + 32'h10, 1'b1, RPC + 32'hc);
        tbl[8] = mk(1'b0, 1'b0, 32'h0,                  1'b1, RPC + 32'h10, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            inst_addr_ok = tbl[i].aok;
            inst_data_ok = tbl[i].dok;
            inst_rdata   = tbl[i].rd;
            id_allow_in  = 1'b1;
            chk($sformatf("t1_r%0d_req", i), 32'(inst_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("t1_r%0d_addr", i), inst_addr, tbl[i].e_addr);
            chk($sformatf("t1_r%0d_valid", i), 32'(if_valid_out), 32'(tbl[i].e_valid));
            chk($sformatf("t1_r%0d_adef", i), 32'(if_adef), 32'h0);
            if (tbl[i].e_valid) begin
                chk($sformatf("t1_r%0d_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("t1_r%0d_inst", i), if_inst, tbl[i].e_inst);
            end
            @(posedge aclk);
            @(negedge aclk);
        end

        // Test 2: ID stalls for 5 cycles; occupancy capped, nothing lost or reordered.
        do_reset();
        cycles(4);
        id_allow_in = 1'b0;
        cycles(5);
        chk("t2_req_dropped", 32'(inst_req), 32'h0);
        chk("t2_head_pc", if_pc, RPC + 32'h4);
        chk("t2_head_valid", 32'(if_valid_out), 32'h1);
        id_allow_in = 1'b1;
        cycles(14);
        chk("t2_max_outstanding_le2", 32'(max_out <= 2), 32'h1);
        check_deliv("t2", RPC, 6);

        // Test 3: two requests in flight, then a taken branch.
        do_reset();
        resp_en = 1'b0;
        cycles(3);
        br_taken = 1'b1; br_target = 32'h1c00_0100;
        cyc();
        br_taken = 1'b0;
        resp_en = 1'b1;
        chk("t3_req", 32'(inst_req), 32'h1);
        chk("t3_addr", inst_addr, 32'h1c00_0100);
        cycles(14);
        check_deliv("t3", 32'h1c00_0100, 4);

        // Test 4: redirect while a request waits for addr_ok.
        do_reset();
        aok_en = 1'b0;
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0200;
        cyc();
        redirect_valid = 1'b0;
        chk("t4_hold_req", 32'(inst_req), 32'h1);
        chk("t4_hold_addr", inst_addr, RPC);
        cyc();
        chk("t4_hold_addr2", inst_addr, RPC);
        aok_en = 1'b1;
        cyc();
        chk("t4_new_req", 32'(inst_req), 32'h1);
        chk("t4_new_addr", inst_addr, 32'h1c00_0200);
        cycles(14);
        check_deliv("t4", 32'h1c00_0200, 4);

        // Test 5: branch to a misaligned target, ADEF held until a redirect.
        do_reset();
        cycles(4);
        br_taken = 1'b1; br_target = 32'h1c00_0102;
        cyc();
        br_taken = 1'b0;
        req_seen = 1'b0;
        chk("t5_valid", 32'(if_valid_out), 32'h1);
        chk("t5_adef", 32'(if_adef), 32'h1);
        chk("t5_pc", if_pc, 32'h1c00_0102);
        chk("t5_inst", if_inst, 32'h0);
        cycles(5);
        chk("t5_no_req", 32'(req_seen), 32'h0);
        chk("t5_held_adef", 32'(if_adef), 32'h1);
        chk("t5_held_pc", if_pc, 32'h1c00_0102);
        redirect_valid = 1'b1; redirect_pc = RPC;
        dpc.delete(); dinst.delete();
        cyc();
        redirect_valid = 1'b0;
        chk("t5_resume_req", 32'(inst_req), 32'h1);
        chk("t5_resume_addr", inst_addr, RPC);
        chk("t5_resume_adef", 32'(if_adef), 32'h0);
        cycles(10);
        check_deliv("t5", RPC, 3);

        // Test 6: redirect, branch, response and accept all in one cycle.
        do_reset();
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0300;
        br_taken = 1'b1; br_target = 32'h1c00_0400;
        cyc();
        redirect_valid = 1'b0; br_taken = 1'b0;
        chk("t6_addr", inst_addr, 32'h1c00_0300);
        chk("t6_valid", 32'(if_valid_out), 32'h0);
        cycles(14);
        check_deliv("t6", 32'h1c00_0300, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
